// File: rtl/apb_ram_param.sv
// APB4 completer backed by a flop-based word RAM. It supports byte strobes, fixed wait states,
// alignment/range error responses, and abort when psel drops during the wait phase.
module apb_ram_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << LSB) - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [3:0]            r_wcnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic                  w_mis, w_oor, w_err, w_setup, w_commit;
  logic [IDXW-1:0]       w_idx;
  logic [DATA_WIDTH-1:0] w_rd, w_merge, w_resp_data;

  // The range check uses the full paddr so that high address bits cannot alias into the RAM.
  assign w_mis       = |(paddr & LOW_MASK);
  assign w_oor       = |(paddr >> (LSB + IDXW));
  assign w_err       = w_mis | w_oor;
  assign w_idx       = paddr[LSB +: IDXW];
  assign w_rd        = r_mem[w_idx];
  assign w_setup     = psel & ~penable;
  assign w_commit    = psel & penable & pwrite & ~w_err;
  assign w_resp_data = (w_err | pwrite) ? '0 : w_rd;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign w_merge[8*b +: 8] = pstrb[b] ? pwdata[8*b +: 8] : w_rd[8*b +: 8];
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_wcnt <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              r_state   <= S_RESP;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_resp_data;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
          end else if (r_wcnt <= 4'd1) begin
            r_state   <= S_RESP;
            r_wcnt    <= '0;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= w_resp_data;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
          if (w_commit) r_mem[w_idx] <= w_merge;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;

endmodule
